// File: rtl/pa_idu_sp_rd_ctrl_pkg.sv
// Shared definitions for the IDU stack-pointer read controller: SP scoreboard
// busy encodings (common with the SP write side), read FSM states and the
// "operand is architecturally safe" decode.
package pa_idu_sp_rd_ctrl_pkg;

  // SP scoreboard busy-state encodings
  localparam logic [2:0] BUSY_IDLE = 3'b000;
  localparam logic [2:0] BUSY1     = 3'b001;
  localparam logic [2:0] BUSY_LSU1 = 3'b010;
  localparam logic [2:0] BUSY_DIV1 = 3'b011;
  localparam logic [2:0] BUSY2     = 3'b100;
  localparam logic [2:0] BUSY_LSU2 = 3'b110;
  localparam logic [2:0] BUSY_DIV2 = 3'b111;

  // Read-side FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_VLD  = 2'b10
  } sp_rd_state_e;

  // SP value may be sampled this cycle: either nobody owns it, or the single
  // outstanding writer is forwarding right now. With two writers in flight the
  // value on reg_dout_y is never final, so every *2 state is unsafe.
  function automatic logic sp_rd_safe(input logic [2:0] busy_st,
                                      input logic       fwd0,
                                      input logic       fwd1,
                                      input logic       fwd2);
    logic safe;
    case (busy_st)
      BUSY_IDLE: safe = 1'b1;
      BUSY1:     safe = fwd0 | fwd1 | fwd2;
      BUSY_LSU1: safe = fwd1 | fwd2;
      BUSY_DIV1: safe = fwd0 | fwd2;
      BUSY2:     safe = 1'b0;
      BUSY_LSU2: safe = 1'b0;
      BUSY_DIV2: safe = 1'b0;
      default:   safe = 1'b0;
    endcase
    return safe;
  endfunction

endpackage

// File: rtl/pa_idu_sp_rd_ctrl_gated_clk.sv
// Latch-based integrated clock gate. The enable is captured while the clock
// is low so the gated clock never glitches; scan enable forces the clock on.
// module_en set means gating is allowed, clear means the clock free-runs
// (subject to global_en).
module gated_clk_cell (
  input  logic clk_in,
  input  logic global_en,
  input  logic module_en,
  input  logic local_en,
  input  logic external_en,
  input  logic pad_yy_icg_scan_en,
  output logic clk_out
);

  logic clk_en_bf_latch_s;
  logic clk_en_q;

  assign clk_en_bf_latch_s = (global_en & (~module_en | local_en)) | external_en;

  // Transparent-low enable latch
  always_latch begin
    if (!clk_in) begin
      clk_en_q = clk_en_bf_latch_s | pad_yy_icg_scan_en;
    end
  end

  assign clk_out = clk_in & clk_en_q;

endmodule

// File: rtl/pa_idu_sp_rd_ctrl.sv
// IDU stack-pointer read controller. Holds a decoder SP read request until the
// scoreboard says the value is final (or being forwarded this cycle), captures
// it, and hands it over with a valid/pop handshake. Also counts wait cycles per
// request and pulses a hang indication when the wait reaches STALL_LIMIT.
module pa_idu_sp_rd_ctrl
  import pa_idu_sp_rd_ctrl_pkg::*;
#(
  parameter int unsigned      CNT_W       = 8,
  parameter logic [CNT_W-1:0] STALL_LIMIT = 8'd200
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst_b,
  input  logic             cp0_yy_clk_en,
  input  logic             cp0_idu_icg_en,
  input  logic             pad_yy_icg_scan_en,
  input  logic             dec_sp_rd_req,
  input  logic             dec_sp_rd_pop,
  input  logic [2:0]       reg_busy_st_y,
  input  logic [31:0]      reg_dout_y,
  input  logic             reg_fwd_en0_x,
  input  logic             reg_fwd_en1_x,
  input  logic             reg_fwd_en2_x,
  input  logic             rtu_idu_flush_fe,
  output logic [31:0]      sp_rd_data,
  output logic             sp_rd_vld,
  output logic             sp_rd_stall,
  output logic [CNT_W-1:0] sp_rd_stall_cnt,
  output logic             sp_rd_hang
);

  logic             sp_clk_s;
  logic             safe_s;
  logic             local_en_s;
  logic             cnt_sat_s;
  logic [CNT_W-1:0] cnt_inc_s;

  sp_rd_state_e     state_q, state_d;
  logic [31:0]      data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hang_q, hang_d;

  assign safe_s = sp_rd_safe(reg_busy_st_y, reg_fwd_en0_x, reg_fwd_en1_x, reg_fwd_en2_x);

  // Clock only runs while there is something to do: a request, a live FSM
  // state, or a flush that has to pull the FSM back to idle.
  assign local_en_s = dec_sp_rd_req | (state_q != S_IDLE) | rtu_idu_flush_fe;

  gated_clk_cell x_sp_rd_gated_clk (
    .clk_in             (forever_cpuclk),
    .global_en          (cp0_yy_clk_en),
    .module_en          (cp0_idu_icg_en),
    .local_en           (local_en_s),
    .external_en        (1'b0),
    .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
    .clk_out            (sp_clk_s)
  );

  assign cnt_sat_s = &cnt_q;
  assign cnt_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // Next-state, capture, stall counter and hang decode; flush overrides all
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    hang_d  = 1'b0;
    if (rtu_idu_flush_fe) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (dec_sp_rd_req) begin
            cnt_d = {CNT_W{1'b0}};
            if (safe_s) begin
              data_d  = reg_dout_y;
              state_d = S_VLD;
            end else begin
              state_d = S_WAIT;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WAIT: begin
          if (safe_s) begin
            data_d  = reg_dout_y;
            state_d = S_VLD;
          end else if (!cnt_sat_s) begin
            // Counter only moves upward once, so the limit is crossed once
            cnt_d  = cnt_inc_s;
            hang_d = (cnt_inc_s == STALL_LIMIT);
          end else begin
            cnt_d = cnt_q;
          end
        end
        S_VLD: begin
          if (dec_sp_rd_pop) begin
            if (dec_sp_rd_req && safe_s) begin
              // Back-to-back delivery: next operand has zero wait
              data_d = reg_dout_y;
              cnt_d  = {CNT_W{1'b0}};
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_VLD;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, operand, counter and hang flops on the gated clock
  always_ff @(posedge sp_clk_s or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= S_IDLE;
      data_q  <= 32'd0;
      cnt_q   <= {CNT_W{1'b0}};
      hang_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      hang_q  <= hang_d;
    end
  end

  assign sp_rd_data      = data_q;
  assign sp_rd_vld       = (state_q == S_VLD);
  assign sp_rd_stall     = cpurst_b & dec_sp_rd_req & ~safe_s & (state_q != S_VLD);
  assign sp_rd_stall_cnt = cnt_q;
  assign sp_rd_hang      = hang_q;

endmodule

// File: tb/tb_pa_idu_sp_rd_ctrl.sv
// Directed bench for pa_idu_sp_rd_ctrl. Inputs change 2 time units after the
// rising edge; registered outputs are checked from there, combinational
// stall 1 unit later, and the scoreboard monitor samples on the falling edge.
module tb_pa_idu_sp_rd_ctrl;

  logic        clk = 1'b0;
  logic        cpurst_b;
  logic        clk_en, icg_en, scan_en;
  logic        req, pop, flush;
  logic [2:0]  busy;
  logic [31:0] dout;
  logic        fwd0, fwd1, fwd2;
  logic [31:0] sp_rd_data;
  logic        sp_rd_vld, sp_rd_stall, sp_rd_hang;
  logic [7:0]  sp_rd_stall_cnt;

  int          n_vec = 0;
  int          n_err = 0;
  int          hang_seen;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pa_idu_sp_rd_ctrl #(.CNT_W(8), .STALL_LIMIT(8'd8)) dut (
    .forever_cpuclk     (clk),
    .cpurst_b           (cpurst_b),
    .cp0_yy_clk_en      (clk_en),
    .cp0_idu_icg_en     (icg_en),
    .pad_yy_icg_scan_en (scan_en),
    .dec_sp_rd_req      (req),
    .dec_sp_rd_pop      (pop),
    .reg_busy_st_y      (busy),
    .reg_dout_y         (dout),
    .reg_fwd_en0_x      (fwd0),
    .reg_fwd_en1_x      (fwd1),
    .reg_fwd_en2_x      (fwd2),
    .rtu_idu_flush_fe   (flush),
    .sp_rd_data         (sp_rd_data),
    .sp_rd_vld          (sp_rd_vld),
    .sp_rd_stall        (sp_rd_stall),
    .sp_rd_stall_cnt    (sp_rd_stall_cnt),
    .sp_rd_hang         (sp_rd_hang)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard monitor: every accepted operand must match the oldest expected one
  always @(negedge clk) begin
    if (cpurst_b && sp_rd_vld && pop) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_extra: got %h with no operand expected", sp_rd_data);
      end else begin
        chk("sb_data", sp_rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    cpurst_b = 1'b0; clk_en = 1'b1; icg_en = 1'b1; scan_en = 1'b0;
    req = 1'b0; pop = 1'b0; flush = 1'b0; busy = 3'b000; dout = 32'd0;
    fwd0 = 1'b0; fwd1 = 1'b0; fwd2 = 1'b0;

    // Reset state: outputs zero, stall held low even with a request present
    repeat (2) cyc();
    req = 1'b1; busy = 3'b001; #1;
    chk("rst_stall", 32'(sp_rd_stall), 32'd0);
    chk("rst_vld",   32'(sp_rd_vld),   32'd0);
    chk("rst_data",  sp_rd_data,       32'd0);
    chk("rst_cnt",   32'(sp_rd_stall_cnt), 32'd0);
    chk("rst_hang",  32'(sp_rd_hang),  32'd0);
    req = 1'b0; busy = 3'b000;
    cyc(); cpurst_b = 1'b1;
    cyc();

    // Zero-wait read
    cyc(); busy = 3'b000; req = 1'b1; dout = 32'h2000_0FF0; exp_q.push_back(32'h2000_0FF0);
    #1 chk("t1_stall", 32'(sp_rd_stall), 32'd0);
    cyc(); chk("t1_vld", 32'(sp_rd_vld), 32'd1); req = 1'b0; pop = 1'b1; dout = 32'hDEAD_BEEF;
    cyc(); pop = 1'b0; chk("t1_vld_clr", 32'(sp_rd_vld), 32'd0);

    // LSU1 busy: request cycle stalls, then 5 counted wait cycles, then forward on en1
    cyc(); busy = 3'b010; req = 1'b1; dout = 32'h0000_1111;
    #1 chk("t2_stall_idle", 32'(sp_rd_stall), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      chk("t2_stall_wait", 32'(sp_rd_stall), 32'd1);
      chk("t2_cnt_run", 32'(sp_rd_stall_cnt), 32'(i));
    end
    cyc(); fwd1 = 1'b1; dout = 32'h0000_1234; exp_q.push_back(32'h0000_1234);
    #1 chk("t2_stall_fwd", 32'(sp_rd_stall), 32'd0);
    chk("t2_cnt5", 32'(sp_rd_stall_cnt), 32'd5);
    cyc(); fwd1 = 1'b0; busy = 3'b000; req = 1'b0; pop = 1'b1; dout = 32'hDEAD_BEEF;
    chk("t2_vld", 32'(sp_rd_vld), 32'd1);
    chk("t2_cnt_hold", 32'(sp_rd_stall_cnt), 32'd5);
    cyc(); pop = 1'b0; chk("t2_vld_clr", 32'(sp_rd_vld), 32'd0);

    // Two writers (DIV2): ALU forward is not enough, then DIV1 ignores en1, takes en2
    cyc(); busy = 3'b111; req = 1'b1; dout = 32'h5555_5555;
    #1 chk("t3_stall_div2", 32'(sp_rd_stall), 32'd1);
    cyc(); fwd0 = 1'b1;
    #1 chk("t3_stall_div2_fwd0", 32'(sp_rd_stall), 32'd1);
    cyc(); fwd0 = 1'b0; busy = 3'b011; fwd1 = 1'b1;
    #1 chk("t3_stall_div1_fwd1", 32'(sp_rd_stall), 32'd1);
    cyc(); fwd1 = 1'b0; fwd2 = 1'b1; dout = 32'hABCD_0011; exp_q.push_back(32'hABCD_0011);
    #1 chk("t3_stall_div1_fwd2", 32'(sp_rd_stall), 32'd0);
    chk("t3_vld_pre", 32'(sp_rd_vld), 32'd0);
    cyc(); fwd2 = 1'b0; busy = 3'b000; req = 1'b0; pop = 1'b1;
    chk("t3_vld", 32'(sp_rd_vld), 32'd1);
    chk("t3_cnt", 32'(sp_rd_stall_cnt), 32'd2);
    cyc(); pop = 1'b0;

    // Long stall: hang once at 8, counter saturates at 255
    cyc(); busy = 3'b001; req = 1'b1; dout = 32'h7777_0000;
    hang_seen = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(); #1;
      if (sp_rd_hang) hang_seen++;
      if (i == 8) begin
        chk("t4_hang_at_limit", 32'(sp_rd_hang), 32'd1);
        chk("t4_cnt_at_limit", 32'(sp_rd_stall_cnt), 32'd8);
      end
    end
    chk("t4_hang_once", 32'(hang_seen), 32'd1);
    chk("t4_cnt_sat", 32'(sp_rd_stall_cnt), 32'd255);
    cyc(); fwd0 = 1'b1; exp_q.push_back(32'h7777_0000);
    cyc(); fwd0 = 1'b0; busy = 3'b000; req = 1'b0; pop = 1'b1;
    chk("t4_vld", 32'(sp_rd_vld), 32'd1);
    cyc(); pop = 1'b0;

    // Flush in S_WAIT: returns to idle, counter held, no hang
    cyc(); busy = 3'b100; req = 1'b1; dout = 32'h0000_0BAD;
    cyc();
    cyc(); flush = 1'b1; fwd0 = 1'b1;
    #1 chk("t5_stall_flush", 32'(sp_rd_stall), 32'd1);
    cyc(); flush = 1'b0; fwd0 = 1'b0;
    #1 chk("t5_vld", 32'(sp_rd_vld), 32'd0);
    chk("t5_cnt_hold", 32'(sp_rd_stall_cnt), 32'd1);
    chk("t5_hang", 32'(sp_rd_hang), 32'd0);
    // Idle would clear the counter here; a stuck wait state would bump it to 2
    cyc(); #1 chk("t5_idle_after_flush", 32'(sp_rd_stall_cnt), 32'd0);
    busy = 3'b000; dout = 32'h0000_9999; exp_q.push_back(32'h0000_9999);
    cyc(); req = 1'b0; pop = 1'b1; chk("t5_vld2", 32'(sp_rd_vld), 32'd1);
    cyc(); pop = 1'b0;

    // Request arriving together with flush is ignored
    cyc(); busy = 3'b000; req = 1'b1; flush = 1'b1; dout = 32'h0000_FEED;
    cyc(); flush = 1'b0; req = 1'b0;
    #1 chk("t5_req_flush_ign", 32'(sp_rd_vld), 32'd0);

    // Flush in S_VLD: valid dropped, data held
    cyc(); req = 1'b1; dout = 32'hCAFE_F00D;
    cyc(); chk("t5_vld_pre_flush", 32'(sp_rd_vld), 32'd1); req = 1'b0; flush = 1'b1;
    cyc(); flush = 1'b0;
    chk("t5_vld_flushed", 32'(sp_rd_vld), 32'd0);
    chk("t5_data_held", sp_rd_data, 32'hCAFE_F00D);
    chk("t5_hang_vld", 32'(sp_rd_hang), 32'd0);

    // Back-to-back delivery with continuous pop
    cyc(); req = 1'b1; dout = 32'h1000_0000; exp_q.push_back(32'h1000_0000);
    cyc(); chk("t6_vld0", 32'(sp_rd_vld), 32'd1); pop = 1'b1; dout = 32'h1000_0004; exp_q.push_back(32'h1000_0004);
    cyc(); chk("t6_vld1", 32'(sp_rd_vld), 32'd1); dout = 32'h1000_0008; exp_q.push_back(32'h1000_0008);
    cyc(); chk("t6_vld2", 32'(sp_rd_vld), 32'd1); req = 1'b0;
    cyc(); pop = 1'b0; chk("t6_vld_clr", 32'(sp_rd_vld), 32'd0);

    // Asynchronous reset while holding a delivered operand
    cyc(); req = 1'b1; busy = 3'b001; dout = 32'h0F0F_F0F0;
    cyc();
    cyc();
    cyc(); fwd0 = 1'b1;
    cyc(); fwd0 = 1'b0;
    chk("t7_vld", 32'(sp_rd_vld), 32'd1);
    chk("t7_cnt", 32'(sp_rd_stall_cnt), 32'd2);
    #1 cpurst_b = 1'b0;
    #1;
    chk("t7_rst_vld",   32'(sp_rd_vld),   32'd0);
    chk("t7_rst_data",  sp_rd_data,       32'd0);
    chk("t7_rst_cnt",   32'(sp_rd_stall_cnt), 32'd0);
    chk("t7_rst_stall", 32'(sp_rd_stall), 32'd0);
    chk("t7_rst_hang",  32'(sp_rd_hang),  32'd0);
    cyc(); req = 1'b0; busy = 3'b000; cpurst_b = 1'b1;
    cyc();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pa_idu_sp_rd_ctrl.md
# pa_idu_sp_rd_ctrl

Read-side controller for the IDU stack-pointer register. Consumes the busy-state scoreboard and the forwarded-data output of the SP write side, and holds a decoder's SP read request until the value is architecturally safe. Samples and delivers the operand with a valid/pop handshake, and reports per-request stall cycles and hang detection to debug and performance logic.

## Interface
- STALL_LIMIT, 8'd200: wait cycles after which `sp_rd_hang` pulses.
- CNT_W, 8: width of the saturating stall counter.
- forever_cpuclk  in  1  free-running core clock.
- cpurst_b  in  1  reset, asynchronous, active-low.
- cp0_yy_clk_en, cp0_idu_icg_en, pad_yy_icg_scan_en  in  1 each  ICG controls.
- dec_sp_rd_req  in  1  decoder requests SP operand; level, held until `sp_rd_vld`.
- dec_sp_rd_pop  in  1  consumer takes the delivered operand.
- reg_busy_st_y  in  3  SP scoreboard state.
- reg_dout_y  in  32  SP value including same-cycle forwarding.
- reg_fwd_en0_x, reg_fwd_en1_x, reg_fwd_en2_x  in  1 each  writeback/forward strobes (ALU, LSU, DIV).
- rtu_idu_flush_fe  in  1  front-end flush.
- sp_rd_data  out  32  captured SP operand; reset 0.
- sp_rd_vld  out  1  operand valid; reset 0.
- sp_rd_stall  out  1  request present but not serviceable; combinational; 0 in reset.
- sp_rd_stall_cnt  out  CNT_W  wait cycles of current or last request; reset 0.
- sp_rd_hang  out  1  one-cycle pulse; reset 0.

## Operation
- Busy encodings: IDLE 000, BUSY1 001, BUSY_LSU1 010, BUSY_DIV1 011, BUSY2 100, BUSY_LSU2 110, BUSY_DIV2 111.
- `safe` (combinational):
  - IDLE: 1.
  - BUSY1: any fwd_en.
  - BUSY_LSU1: fwd_en1 | fwd_en2.
  - BUSY_DIV1: fwd_en0 | fwd_en2.
  - Any *2 state: 0.
  - Other encodings: 0.
- FSM states: S_IDLE, S_WAIT, S_VLD.
  - S_IDLE, req & safe: capture reg_dout_y, clear counter, go to S_VLD.
  - S_IDLE, req & ~safe: clear counter, go to S_WAIT.
  - S_WAIT, safe: capture, go to S_VLD.
  - S_WAIT, ~safe: counter +1, saturating at all-ones.
  - S_VLD: `sp_rd_vld`=1; pop returns to S_IDLE. A pop coinciding with req & safe recaptures and stays in S_VLD (back-to-back delivery).
- `sp_rd_stall` = req & ~safe & (state != S_VLD).
- `sp_rd_hang` pulses on the cycle the counter transitions to STALL_LIMIT while in S_WAIT. It fires once per request.
- Flush has priority over all transitions: next state S_IDLE, vld cleared, data held, counter held. A request arriving with flush is ignored that cycle.
- Pop outside S_VLD is ignored.
- Local ICG enable = req | (state != S_IDLE) | flush.

## Timing
- Zero-wait read: req in cycle N with safe → `sp_rd_vld`=1 in N+1, data = reg_dout_y sampled at N.
- Forward-satisfied read: fwd strobe in cycle M → vld in M+1 with forwarded value.
- Throughput: one operand per cycle with continuous pop.
- Reset mid-request: all outputs return to reset values asynchronously; FSM to S_IDLE.
- Counter width rule: increment in CNT_W bits, saturating; STALL_LIMIT must be < 2^CNT_W.

## Structure
- Shared package: busy-state encodings (shared with the SP write side), FSM state constants.
- One sub-module: gated_clk_cell (x_sp_rd_gated_clk) clocking state, data, and counter flops.
- Everything else flat: `safe` decode, FSM, capture register, counter.

## Test plan
- Busy=000, req=1, reg_dout_y=0x2000_0FF0 → next cycle vld=1, data=0x2000_0FF0; pop → vld=0.
- Busy=010 for 5 cycles, then fwd_en1 with reg_dout_y=0x1234 → stall=1 for 5 cycles, vld next cycle, data=0x1234, cnt=5.
- Busy=111, fwd_en0 pulses → stall persists (two writers); vld only after the state reaches 011 and fwd_en2 asserts.
- Held in S_WAIT with STALL_LIMIT=8 → hang pulses exactly once as cnt reaches 8; cnt saturates at 255 after a long stall.
- Flush while in S_WAIT and while in S_VLD → next cycle state S_IDLE, vld=0, no hang.
- Async reset asserted in S_VLD → vld=0, data=0, cnt=0 immediately.
